// File: rtl/tube_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tube_pkg
// Brief   : Shared widths, state codes and reset constants for the tube scanner.
// Revision: 1.0 - initial release
// ============================================================================
package tube_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int DIG_W      = 2;

    localparam logic [DIGIT_W-1:0]    AUX_EMPTY      = 4'h0;
    localparam logic [NUM_DIGITS-1:0] AUX_RESET_MASK = 4'hF;

    typedef logic [0:0] tube_state_t;
    localparam tube_state_t ST_SHOW  = 1'b0;
    localparam tube_state_t ST_BLANK = 1'b1;

endpackage : tube_pkg
`default_nettype wire

// File: rtl/tube_slot_timer.sv
`default_nettype none
// ============================================================================
// Module  : tube_slot_timer
// Brief   : Slot counter and SHOW/BLANK sequencer; advances the scanned digit.
// Revision: 1.0 - initial release
// ============================================================================
module tube_slot_timer
    import tube_pkg::*;
#(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic             clk,
    input  logic             reset,
    output tube_state_t      state_o,
    output logic [DIG_W-1:0] dig_o,
    output logic             slotEnd_o,
    output logic             frameEnd_o
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    tube_state_t      state_q, state_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic             slotEnd;

    always_comb begin
        slotEnd = (state_q == ST_SHOW) ? (cnt_q == SHOW_LAST) : (cnt_q == BLANK_LAST);
        cnt_d   = slotEnd ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        dig_d   = dig_q;
        if (slotEnd) begin
            if (state_q == ST_SHOW) begin
                state_d = ST_BLANK;
            end else begin
                // Digit only moves while blanked, so a switch is never visible.
                state_d = ST_SHOW;
                dig_d   = dig_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            state_q <= ST_BLANK;
            dig_q   <= DIG_W'(NUM_DIGITS - 1);
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            dig_q   <= dig_d;
        end
    end

    assign state_o    = state_q;
    assign dig_o      = dig_q;
    assign slotEnd_o  = slotEnd;
    assign frameEnd_o = slotEnd & (state_q == ST_BLANK) & (dig_q == DIG_W'(NUM_DIGITS - 1));

endmodule : tube_slot_timer
`default_nettype wire

// File: rtl/tube_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tube_scan_scheduler
// Brief   : 4-digit tube scan with blanking gap and frame-synchronous double
//           buffered display data. Optional PWM dimming with TUBE_PWM_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tube_scan_scheduler
    import tube_pkg::*;
#(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wrValid,
    output logic                            wrReady,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   wrDigits,
    input  logic [NUM_DIGITS-1:0]           wrDots,
    input  logic [NUM_DIGITS-1:0]           wrAuxs,
`ifdef TUBE_PWM_EN
    input  logic [3:0]                      brightness,
`endif
    output logic [DIG_W-1:0]                dig,
    output logic [DIGIT_W-1:0]              dig1,
    output logic [DIGIT_W-1:0]              dig2,
    output logic [DIGIT_W-1:0]              dig3,
    output logic [DIGIT_W-1:0]              dig4,
    output logic [NUM_DIGITS-1:0]           dots,
    output logic [NUM_DIGITS-1:0]           auxs,
    output logic                            blank,
    output logic                            frameTick
);

    tube_state_t state;
    logic        slotEnd;
    logic        commit;
    logic        accept;

    tube_slot_timer #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .state_o    (state),
        .dig_o      (dig),
        .slotEnd_o  (slotEnd),
        .frameEnd_o (commit)
    );

    logic                          pend_q, pend_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] pendDigits_q, pendDigits_d;
    logic [NUM_DIGITS-1:0]         pendDots_q, pendDots_d;
    logic [NUM_DIGITS-1:0]         pendAuxs_q, pendAuxs_d;
    logic [NUM_DIGITS*DIGIT_W-1:0] actDigits_q, actDigits_d;
    logic [NUM_DIGITS-1:0]         actDots_q, actDots_d;
    logic [NUM_DIGITS-1:0]         actAuxs_q, actAuxs_d;
    logic                          frameTick_q;

    assign accept = wrValid & ~pend_q;

    always_comb begin
        pendDigits_d = pendDigits_q;
        pendDots_d   = pendDots_q;
        pendAuxs_d   = pendAuxs_q;
        actDigits_d  = actDigits_q;
        actDots_d    = actDots_q;
        actAuxs_d    = actAuxs_q;
        pend_d       = pend_q;
        // A commit needs pend_q=1 and an accept needs pend_q=0, so they never collide.
        if (commit && pend_q) begin
            actDigits_d = pendDigits_q;
            actDots_d   = pendDots_q;
            actAuxs_d   = pendAuxs_q;
            pend_d      = 1'b0;
        end
        if (accept) begin
            pendDigits_d = wrDigits;
            pendDots_d   = wrDots;
            pendAuxs_d   = wrAuxs;
            pend_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q       <= 1'b0;
            pendDigits_q <= '0;
            pendDots_q   <= '0;
            pendAuxs_q   <= '0;
            actDigits_q  <= {NUM_DIGITS{AUX_EMPTY}};
            actDots_q    <= '0;
            actAuxs_q    <= AUX_RESET_MASK;
            frameTick_q  <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            pendDigits_q <= pendDigits_d;
            pendDots_q   <= pendDots_d;
            pendAuxs_q   <= pendAuxs_d;
            actDigits_q  <= actDigits_d;
            actDots_q    <= actDots_d;
            actAuxs_q    <= actAuxs_d;
            frameTick_q  <= commit;
        end
    end

`ifdef TUBE_PWM_EN
    logic [3:0] brightReg_q;
    logic [3:0] pwmCnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brightReg_q <= 4'hF;
            pwmCnt_q    <= 4'h0;
        end else begin
            pwmCnt_q <= pwmCnt_q + 4'h1;
            if (commit) begin
                brightReg_q <= brightness;
            end
        end
    end

    assign blank = (state == ST_BLANK) | (pwmCnt_q > brightReg_q);
`else
    assign blank = (state == ST_BLANK);
`endif

    assign wrReady   = ~pend_q;
    assign dig1      = actDigits_q[DIGIT_W*0 +: DIGIT_W];
    assign dig2      = actDigits_q[DIGIT_W*1 +: DIGIT_W];
    assign dig3      = actDigits_q[DIGIT_W*2 +: DIGIT_W];
    assign dig4      = actDigits_q[DIGIT_W*3 +: DIGIT_W];
    assign dots      = actDots_q;
    assign auxs      = actAuxs_q;
    assign frameTick = frameTick_q;

    // slotEnd is consumed inside the timer; kept on the port list for observability.
    logic unused_slotEnd;
    assign unused_slotEnd = slotEnd;

endmodule : tube_scan_scheduler
`default_nettype wire

// File: tb/tb_tube_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_tube_scan_scheduler
// Brief   : Directed + randomized check of tube_scan_scheduler against a
//           cycle-count based reference model (PRESCALE=8, BLANK_CYCLES=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_tube_scan_scheduler;

    localparam int P = 8;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wrValid = 1'b0;
    logic        wrReady;
    logic [15:0] wrDigits = '0;
    logic [3:0]  wrDots = '0;
    logic [3:0]  wrAuxs = '0;
    logic [1:0]  dig;
    logic [3:0]  dig1, dig2, dig3, dig4, dots, auxs;
    logic        blank, frameTick;
`ifdef TUBE_PWM_EN
    logic [3:0]  brightness = 4'hF;
`endif

    tube_scan_scheduler #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .wrValid    (wrValid),
        .wrReady    (wrReady),
        .wrDigits   (wrDigits),
        .wrDots     (wrDots),
        .wrAuxs     (wrAuxs),
`ifdef TUBE_PWM_EN
        .brightness (brightness),
`endif
        .dig        (dig),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .dig4       (dig4),
        .dots       (dots),
        .auxs       (auxs),
        .blank      (blank),
        .frameTick  (frameTick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    logic        m_pend;
    logic [15:0] m_bDig, m_aDig;
    logic [3:0]  m_bDot, m_aDot, m_bAux, m_aAux;

    // Expected scan position purely from cycles elapsed since reset release.
    function automatic void timing(input int tt, output logic [1:0] d,
                                   output logic b, output logic ft);
        int s, slot, pos;
        if (tt < B) begin
            d = 2'd3; b = 1'b1; ft = 1'b0;
        end else begin
            s    = tt - B;
            slot = s / P;
            pos  = s % P;
            d    = 2'(slot % 4);
            b    = (pos >= P - B);
            ft   = (pos == 0) && (slot % 4 == 0);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp_v, t);
        end
    endtask

    task automatic check_all();
        logic [1:0] ed;
        logic eb, eft;
        timing(t, ed, eb, eft);
        chk("dig",       32'(dig),       32'(ed));
        chk("blank",     32'(blank),     32'(eb));
        chk("frameTick", 32'(frameTick), 32'(eft));
        chk("wrReady",   32'(wrReady),   32'(!m_pend));
        chk("digits",    32'({dig4, dig3, dig2, dig1}), 32'(m_aDig));
        chk("dots",      32'(dots),      32'(m_aDot));
        chk("auxs",      32'(auxs),      32'(m_aAux));
    endtask

    // Check the current cycle, drive inputs, advance model and DUT by one clock.
    task automatic cyc(input logic v, input logic [15:0] d, input logic [3:0] dt,
                       input logic [3:0] ax);
        logic [1:0] nd;
        logic nb, nft, acc;
        check_all();
        wrValid  = v;
        wrDigits = d;
        wrDots   = dt;
        wrAuxs   = ax;
        acc = v && !m_pend;
        timing(t + 1, nd, nb, nft);
        if (nft && m_pend) begin
            m_aDig = m_bDig; m_aDot = m_bDot; m_aAux = m_bAux;
        end
        if (acc) begin
            m_bDig = d; m_bDot = dt; m_bAux = ax;
        end
        m_pend = acc ? 1'b1 : (nft ? 1'b0 : m_pend);
        @(posedge clk);
        t++;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) idle();
    endtask

    // kind 0: dig==val and unblanked; 1: frame-start cycle; 2: cycle before frame start
    task automatic wait_for(input int kind, input int val, input logic v,
                            input logic [15:0] d, input logic [3:0] dt, input logic [3:0] ax);
        logic [1:0] ed;
        logic eb, eft, hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (kind == 2) timing(t + 1, ed, eb, eft);
            else           timing(t, ed, eb, eft);
            if (kind == 0) hit = (32'(ed) == val) && !eb;
            else           hit = eft;
            if (!hit) cyc(v, d, dt, ax);
        end
        chk("wait_bound", 32'(hit), 32'd1);
    endtask

    task automatic do_reset();
        wrValid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("rst_dig",     32'(dig),     32'd3);
        chk("rst_blank",   32'(blank),   32'd1);
        chk("rst_auxs",    32'(auxs),    32'hF);
        chk("rst_wrReady", 32'(wrReady), 32'd1);
        chk("rst_digits",  32'({dig4, dig3, dig2, dig1}), 32'd0);
        chk("rst_dots",    32'(dots),    32'd0);
        chk("rst_ft",      32'(frameTick), 32'd0);
        m_pend = 1'b0;
        m_bDig = '0; m_bDot = '0; m_bAux = '0;
        m_aDig = '0; m_aDot = '0; m_aAux = 4'hF;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        t = 0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // 1: idle scan after reset release
        idle_n(2);
        chk("t1_ft",  32'(frameTick), 32'd1);
        chk("t1_dig", 32'(dig),       32'd0);
        idle_n(40);

        // 2: single mid-frame write
        wait_for(0, 1, 1'b0, 16'h0, 4'h0, 4'h0);
        cyc(1'b1, 16'h4321, 4'b0101, 4'h0);
        chk("t2_ready_low", 32'(wrReady), 32'd0);
        chk("t2_no_tear",   32'({dig4, dig3, dig2, dig1}), 32'd0);
        wait_for(1, 0, 1'b0, 16'h0, 4'h0, 4'h0);
        chk("t2_digits", 32'({dig4, dig3, dig2, dig1}), 32'h4321);
        chk("t2_dots",   32'(dots),    32'h5);
        chk("t2_auxs",   32'(auxs),    32'h0);
        chk("t2_ready",  32'(wrReady), 32'd1);
        idle();

        // 3: A then B within one frame; B held off until A commits
        wait_for(0, 1, 1'b0, 16'h0, 4'h0, 4'h0);
        cyc(1'b1, 16'h5678, 4'h1, 4'h2);
        wait_for(1, 0, 1'b1, 16'h9ABC, 4'h8, 4'h4);
        chk("t3_A", 32'({dig4, dig3, dig2, dig1}), 32'h5678);
        cyc(1'b1, 16'h9ABC, 4'h8, 4'h4);
        wait_for(1, 0, 1'b0, 16'h0, 4'h0, 4'h0);
        chk("t3_B", 32'({dig4, dig3, dig2, dig1}), 32'h9ABC);
        idle();

        // 4: write in the commit cycle with nothing pending
        wait_for(2, 0, 1'b0, 16'h0, 4'h0, 4'h0);
        cyc(1'b1, 16'h0F0E, 4'hA, 4'h3);
        chk("t4_not_yet", 32'({dig4, dig3, dig2, dig1}), 32'h9ABC);
        chk("t4_pending", 32'(wrReady), 32'd0);
        idle();
        wait_for(1, 0, 1'b0, 16'h0, 4'h0, 4'h0);
        chk("t4_shown", 32'({dig4, dig3, dig2, dig1}), 32'h0F0E);
        idle();

        // 5: reset during SHOW of digit 2 with a write pending
        wait_for(0, 1, 1'b0, 16'h0, 4'h0, 4'h0);
        cyc(1'b1, 16'hDEAD, 4'hF, 4'h0);
        wait_for(0, 2, 1'b0, 16'h0, 4'h0, 4'h0);
        chk("t5_pend", 32'(wrReady), 32'd0);
        do_reset();
        idle_n(80);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            cyc(($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_tube_scan_scheduler
`default_nettype wire
